// File: rtl/arith_pkg.sv
// ============================================================================
// Module      : arith_pkg
// Description : Shared definitions for the ripple adder / serial subtractor
//               arithmetic family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int c_default_width = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Start/done handshake and operand/result bundle of the
//               bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = arith_pkg::c_default_width
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  ready, busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, diff, bout, ovf
    );
endinterface

`default_nettype wire

// File: rtl/fullsubtractor.sv
// ============================================================================
// Module      : fullsubtractor
// Description : One-bit full-subtractor cell, x - y - bin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullsubtractor (
    input  wire logic x,
    input  wire logic y,
    input  wire logic bin,
    output logic      d,
    output logic      bo
);

    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, one bit per clock through a
//               single full-subtractor cell and a borrow flip-flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNTW  = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    serial_subtractor_if.slave bus
);

    localparam logic [CNTW-1:0] c_last_cnt = CNTW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CNTW-1:0]  r_cnt;
    logic             r_brw;
    logic             r_bout;
    logic             r_ovf;
    logic             r_a_msb;
    logic             r_b_msb;

    logic             w_d;
    logic             w_bo;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    fullsubtractor u_cell (
        .x   (r_a_sh[0]),
        .y   (r_b_sh[0]),
        .bin (r_brw),
        .d   (w_d),
        .bo  (w_bo)
    );

    assign w_last     = (r_cnt == c_last_cnt);
    // New difference bit enters at the MSB so the word is aligned after WIDTH shifts
    assign w_res_next = (r_res >> 1) | {w_d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: w_next_state = bus.start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_next_state = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a_sh  <= bus.a;
                        r_b_sh  <= bus.b;
                        r_res   <= '0;
                        r_brw   <= 1'b0;
                        r_cnt   <= '0;
                        r_a_msb <= bus.a[WIDTH-1];
                        r_b_msb <= bus.b[WIDTH-1];
                    end
                end
                ST_RUN: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_res  <= w_res_next;
                    r_brw  <= w_bo;
                    r_cnt  <= r_cnt + CNTW'(1);
                    // Visible results only move on the final bit
                    if (w_last) begin
                        r_diff <= w_res_next;
                        r_bout <= w_bo;
                        r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready = (r_state == ST_IDLE);
    assign bus.busy  = (r_state == ST_RUN);
    assign bus.done  = (r_state == ST_DONE);
    assign bus.diff  = r_diff;
    assign bus.bout  = r_bout;
    assign bus.ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int W  = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    res_t exp_q[$];
    res_t held = '0;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .CNTW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: integer subtraction, then read off modulo result and flags
    function automatic res_t model(int a, int b);
        res_t r;
        int   sa;
        int   sbv;
        int   s;
        r.diff = W'(a - b);
        r.bout = (a < b);
        sa  = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sbv = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        s   = sa - sbv;
        r.ovf = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (reset) begin
            held = '0;
        end else if (bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("diff", int'(bus.diff), int'(e.diff));
                check("bout", int'(bus.bout), int'(e.bout));
                check("ovf",  int'(bus.ovf),  int'(e.ovf));
                held = e;
            end
        end else if (bus.busy) begin
            check("hold_during_run", int'({bus.diff, bus.bout, bus.ovf}), int'(held));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.ready && k < 50) begin
            tick();
            k++;
        end
        if (!bus.ready) check("ready_timeout", 0, 1);
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_ready"}, int'(bus.ready), 1);
        check({tag, "_busy"},  int'(bus.busy),  0);
        check({tag, "_done"},  int'(bus.done),  0);
        check({tag, "_diff"},  int'(bus.diff),  0);
        check({tag, "_bout"},  int'(bus.bout),  0);
        check({tag, "_ovf"},   int'(bus.ovf),   0);
    endtask

    task automatic do_op(int a, int b, bit glitch, bit abort);
        int cyc;
        int d0;
        bit seen;
        wait_ready();
        d0 = n_done;
        bus.start = 1'b1;
        bus.a     = W'(a);
        bus.b     = W'(b);
        exp_q.push_back(model(a, b));
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            bus.start = 1'b0;
            if (glitch && cyc == 2) begin
                bus.start = 1'b1;
                bus.a     = W'(b + 1);
                bus.b     = W'(a);
            end
            if (abort && cyc == 2) begin
                reset = 1'b1;
                exp_q.delete();
                tick();
                reset = 1'b0;
                check_reset_state("abort");
                repeat (10) tick();
                check("done_after_abort", n_done - d0, 0);
                return;
            end
            seen = bus.done;
        end
        check("latency", cyc, W + 1);
        tick();
        check("ready_after_done", int'(bus.ready), 1);
        repeat (3) tick();
        check("done_count", n_done - d0, 1);
    endtask

    initial begin : driver
        int d0;
        int pushes;
        int k;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();
        check_reset_state("post_reset");

        do_op(9, 3, 1'b0, 1'b0);
        do_op(3, 9, 1'b0, 1'b0);
        do_op(0, 1, 1'b0, 1'b0);
        do_op(15, 15, 1'b0, 1'b0);
        do_op(7, 8, 1'b0, 1'b0);
        do_op(8, 1, 1'b0, 1'b0);
        do_op(5, 10, 1'b1, 1'b0);
        do_op(11, 4, 1'b0, 1'b1);
        do_op(6, 2, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)),
                  bit'($urandom_range(0, 1)), 1'b0);
        end

        // Continuous start: a new operation every WIDTH+2 cycles
        wait_ready();
        d0     = n_done;
        pushes = 0;
        bus.a     = W'(12);
        bus.b     = W'(5);
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.ready) begin
                exp_q.push_back(model(12, 5));
                pushes++;
            end
            tick();
        end
        bus.start = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 30) begin
            tick();
            k++;
        end
        tick();
        check("held_drain", exp_q.size(), 0);
        check("held_accepts", pushes, 4);
        check("held_dones", n_done - d0, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor; computes diff = a - b, LSB first, one bit per clock.
- Uses a single full-subtractor cell and a borrow flip-flop.
- Companion to the combinational ripple adder: the same operand width and the same ripple cell structure, folded in time.
- Used where area matters more than latency. Start/done handshake toward the datapath controller.

Parameters:
- WIDTH, 4, operand and result width in bits (must be >= 2)
- CNTW, 3, bit-counter width; must satisfy 2**CNTW > WIDTH

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- ready  output  1  high in IDLE; block accepts start
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse (state DONE)
- diff  output  WIDTH  a - b modulo 2**WIDTH
- bout  output  1  final borrow; 1 iff a < b unsigned
- ovf  output  1  signed overflow: a[MSB] != b[MSB] and diff[MSB] != a[MSB]

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, ovf=0, internal shift regs/borrow/counter=0.
- Reset mid-operation: abort at next edge, all values as above, no done pulse.
- FSM IDLE:
  - start=1 at edge T: load a_sh<=a, b_sh<=b, brw<=0, cnt<=0, go RUN.
  - start=0: stay IDLE.
- FSM RUN, each edge:
  - Cell inputs a_sh[0], b_sh[0], brw.
  - d bit shifted into the result register MSB; a_sh and b_sh shift right.
  - brw <= cell borrow; cnt++.
  - On the edge where cnt==WIDTH-1 (edge T+WIDTH): load diff from the completed shift result, bout <= final borrow, compute ovf from captured operand MSBs, go DONE.
- FSM DONE: done=1 for exactly one cycle; next edge go IDLE unconditionally.
- Latency: start accepted at edge T -> done high in the cycle after edge T+WIDTH. Next start can be accepted at edge T+WIDTH+2.
- Output hold: diff/bout/ovf hold their last result from completion until the next completion or reset. They do not change during RUN; intermediate bits stay in an internal register only.
- start while busy or done: ignored, no queuing. Operand inputs changing during RUN have no effect.
- start held high continuously: a new operation begins each time IDLE is re-entered (back-to-back every WIDTH+2 cycles).
- Arithmetic: modulo 2**WIDTH; no width extension. Unsigned underflow is reported via bout; signed overflow via ovf.
- ready = (state==IDLE); busy = (state==RUN); done = (state==DONE). All decoded from registered state, glitch-free.
- Unused state encoding: recover to IDLE at next edge.

Decomposition:
- Shared package arith_pkg:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10
  - default WIDTH constant, shared with the ripple adder family
- One sub-module fullsubtractor(x, y, bin, d, bo):
  - d = x^y^bin
  - bo = (~x & y) | (~(x^y) & bin)
- Top level holds the FSM, shift registers, counter and output registers.

Test Plan (WIDTH=4):
- Reset, then 9 - 3: start at edge T -> done pulse one cycle after edge T+4; diff=6, bout=0, ovf=0; ready returns next cycle.
- 3 - 9 -> diff=4'hA, bout=1, ovf=0. 0 - 1 -> diff=4'hF, bout=1. 15 - 15 -> diff=0, bout=0.
- Signed overflow: 7 - 8 (i.e. 7 - (-8)) -> diff=4'hF, bout=1, ovf=1. 8 - 1 -> diff=7, bout=0, ovf=1.
- Pulse start again during RUN with different a/b -> ignored; result matches the first operands; exactly one done pulse.
- Assert reset for one cycle at RUN cycle 2 -> next cycle ready=1, busy=0, diff=0, bout=0; no done pulse follows.
- start held high for 20 cycles with a=12, b=5 -> done pulses every 6 cycles, diff=7 each time; diff stays stable between pulses.
